// File: rtl/io_bank_ctrl.sv
// GPIO bank controller: per-pin input synchroniser, glitch filter, hold and sticky edge flags,
// plus registered output data and an output-enable FSM with turnaround dead cycles.
module io_bank_ctrl #(
    parameter int   WIDTH       = 8,
    parameter int   SYNC_STAGES = 2,
    parameter int   FILTER_LEN  = 3,
    parameter int   TURN_CYCLES = 2,
    parameter logic IN_RESET    = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ce_i,
    input  logic             hold_i,
    input  logic [WIDTH-1:0] dout_i,
    input  logic [WIDTH-1:0] oe_i,
    input  logic [WIDTH-1:0] evt_clr_i,
    input  logic [WIDTH-1:0] pad_i,
    output logic [WIDTH-1:0] pad_o,
    output logic [WIDTH-1:0] pad_oe,
    output logic [WIDTH-1:0] din_o,
    output logic [WIDTH-1:0] rise_o,
    output logic [WIDTH-1:0] fall_o
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_TURN  = 2'd1;
    localparam logic [1:0] ST_DRIVE = 2'd2;

    localparam int FW = $clog2(((FILTER_LEN > 0) ? FILTER_LEN : 1) + 1);
    localparam int TW = (TURN_CYCLES > 0) ? $clog2(TURN_CYCLES + 1) : 1;
    localparam logic [FW-1:0] FILT_LAST = (FILTER_LEN > 0) ? FW'(FILTER_LEN - 1) : '0;
    localparam logic [TW-1:0] TURN_LAST = (TURN_CYCLES > 0) ? TW'(TURN_CYCLES - 1) : '0;

    logic [WIDTH-1:0] filt;
    logic [WIDTH-1:0] pad_o_q, pad_o_d;
    logic [WIDTH-1:0] hold_q, hold_d;
    logic [WIDTH-1:0] filt_prev_q, filt_prev_d;
    logic [WIDTH-1:0] rise_q, rise_d;
    logic [WIDTH-1:0] fall_q, fall_d;

    // Edge flags watch the filtered value, so a held din_o never hides an event.
    always_comb begin
        pad_o_d     = ce_i ? dout_i : pad_o_q;
        hold_d      = hold_i ? hold_q : filt;
        filt_prev_d = filt;
        rise_d      = (rise_q & ~evt_clr_i) | (filt & ~filt_prev_q);
        fall_d      = (fall_q & ~evt_clr_i) | (~filt & filt_prev_q);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pad_o_q     <= '0;
            hold_q      <= {WIDTH{IN_RESET}};
            filt_prev_q <= {WIDTH{IN_RESET}};
            rise_q      <= '0;
            fall_q      <= '0;
        end else begin
            pad_o_q     <= pad_o_d;
            hold_q      <= hold_d;
            filt_prev_q <= filt_prev_d;
            rise_q      <= rise_d;
            fall_q      <= fall_d;
        end
    end

    assign pad_o  = pad_o_q;
    assign din_o  = hold_i ? hold_q : filt;
    assign rise_o = rise_q;
    assign fall_o = fall_q;

    generate
        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_pin
            logic [SYNC_STAGES-1:0] sync_q, sync_d;
            logic                   sync_out;
            logic [1:0]             st_q, st_d;
            logic [TW-1:0]          tcnt_q, tcnt_d;
            logic                   oe_q, oe_d;

            always_comb begin
                sync_d = {sync_q[SYNC_STAGES-2:0], pad_i[gi]};
            end

            always_ff @(posedge clk or posedge rst) begin
                if (rst) sync_q <= {SYNC_STAGES{IN_RESET}};
                else     sync_q <= sync_d;
            end

            assign sync_out = sync_q[SYNC_STAGES-1];

            if (FILTER_LEN > 0) begin : g_filt
                logic          filt_q, filt_d;
                logic [FW-1:0] fcnt_q, fcnt_d;

                // Accept a new level only after it has disagreed for FILTER_LEN edges in a row.
                always_comb begin
                    filt_d = filt_q;
                    fcnt_d = '0;
                    if (sync_out != filt_q) begin
                        if (fcnt_q == FILT_LAST) filt_d = sync_out;
                        else                     fcnt_d = fcnt_q + 1'b1;
                    end
                end

                always_ff @(posedge clk or posedge rst) begin
                    if (rst) begin
                        filt_q <= IN_RESET;
                        fcnt_q <= '0;
                    end else begin
                        filt_q <= filt_d;
                        fcnt_q <= fcnt_d;
                    end
                end

                assign filt[gi] = filt_q;
            end else begin : g_nofilt
                assign filt[gi] = sync_out;
            end

            always_comb begin
                st_d   = st_q;
                tcnt_d = tcnt_q;
                if (ce_i) begin
                    case (st_q)
                        ST_IDLE: begin
                            tcnt_d = '0;
                            if (oe_i[gi]) st_d = (TURN_CYCLES > 0) ? ST_TURN : ST_DRIVE;
                        end
                        ST_TURN: begin
                            if (!oe_i[gi]) begin
                                st_d   = ST_IDLE;
                                tcnt_d = '0;
                            end else if (tcnt_q == TURN_LAST) begin
                                st_d   = ST_DRIVE;
                                tcnt_d = '0;
                            end else begin
                                tcnt_d = tcnt_q + 1'b1;
                            end
                        end
                        ST_DRIVE: begin
                            if (!oe_i[gi]) st_d = ST_IDLE;
                        end
                        default: begin
                            st_d   = ST_IDLE;
                            tcnt_d = '0;
                        end
                    endcase
                end
                oe_d = (st_d == ST_DRIVE);
            end

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    st_q   <= ST_IDLE;
                    tcnt_q <= '0;
                    oe_q   <= 1'b0;
                end else begin
                    st_q   <= st_d;
                    tcnt_q <= tcnt_d;
                    oe_q   <= oe_d;
                end
            end

            assign pad_oe[gi] = oe_q;
        end
    endgenerate

endmodule

// File: tb/tb_io_bank_ctrl.sv
// Directed bench for io_bank_ctrl with default parameters; expected values are hand-derived.
module tb_io_bank_ctrl;

    logic       clk;
    logic       rst;
    logic       ce_i;
    logic       hold_i;
    logic [7:0] dout_i;
    logic [7:0] oe_i;
    logic [7:0] evt_clr_i;
    logic [7:0] pad_i;
    logic [7:0] pad_o;
    logic [7:0] pad_oe;
    logic [7:0] din_o;
    logic [7:0] rise_o;
    logic [7:0] fall_o;

    int n_cmp = 0;
    int n_bad = 0;

    io_bank_ctrl dut (
        .clk       (clk),
        .rst       (rst),
        .ce_i      (ce_i),
        .hold_i    (hold_i),
        .dout_i    (dout_i),
        .oe_i      (oe_i),
        .evt_clr_i (evt_clr_i),
        .pad_i     (pad_i),
        .pad_o     (pad_o),
        .pad_oe    (pad_oe),
        .din_o     (din_o),
        .rise_o    (rise_o),
        .fall_o    (fall_o)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end else begin
            $display("ok   %s: 0x%0h", tag, got);
        end
    endtask

    // Advance n rising edges, then settle 1 time unit past the last one.
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        rst       = 1'b1;
        ce_i      = 1'b1;
        hold_i    = 1'b0;
        dout_i    = 8'hFF;
        oe_i      = 8'hFF;
        evt_clr_i = 8'h00;
        pad_i     = 8'hFF;

        // 1) reset with all inputs active
        tick(4);
        check("rst_pad_oe", 32'(pad_oe), 32'h00);
        check("rst_pad_o",  32'(pad_o),  32'h00);
        check("rst_din",    32'(din_o),  32'h00);
        check("rst_rise",   32'(rise_o), 32'h00);
        check("rst_fall",   32'(fall_o), 32'h00);
        pad_i  = 8'h00;
        oe_i   = 8'h00;
        dout_i = 8'h00;
        tick(1);
        rst = 1'b0;
        tick(6);
        check("post_rst_din",   32'(din_o),  32'h00);
        check("post_rst_flags", 32'({rise_o, fall_o}), 32'h0000);
        check("post_rst_oe",    32'(pad_oe), 32'h00);

        // 2) filter latency on bit 0: first sampled at edge n, filt after n+4, flag after n+5
        pad_i = 8'h01;
        tick(4);
        check("filt_n3_din",  32'(din_o),  32'h00);
        tick(1);
        check("filt_n4_din",  32'(din_o),  32'h01);
        check("filt_n4_rise", 32'(rise_o), 32'h00);
        tick(1);
        check("filt_n5_rise", 32'(rise_o), 32'h01);
        // 2-cycle pulse on bit 1 must be rejected
        pad_i = 8'h03;
        tick(2);
        pad_i = 8'h01;
        tick(8);
        check("pulse_din",  32'(din_o),  32'h01);
        check("pulse_rise", 32'(rise_o), 32'h01);
        check("pulse_fall", 32'(fall_o), 32'h00);

        // 3) hold freezes din_o while flags still track filt
        pad_i = 8'h00;
        tick(6);
        check("fall0", 32'(fall_o), 32'h01);
        evt_clr_i = 8'hFF;
        tick(1);
        evt_clr_i = 8'h00;
        check("clr_all", 32'({rise_o, fall_o}), 32'h0000);
        hold_i = 1'b1;
        tick(1);
        pad_i = 8'hFF;
        tick(6);
        check("hold_din",  32'(din_o),  32'h00);
        check("hold_rise", 32'(rise_o), 32'hFF);
        hold_i = 1'b0;
        #1;
        check("unhold_din", 32'(din_o), 32'hFF);
        pad_i = 8'h00;
        tick(6);
        evt_clr_i = 8'hFF;
        tick(1);
        evt_clr_i = 8'h00;
        check("clr_all2", 32'({rise_o, fall_o}), 32'h0000);

        // 4) OE turnaround on bit 3 and pad_o latency
        oe_i   = 8'h08;
        dout_i = 8'h3C;
        tick(1);
        check("turn_e0",  32'(pad_oe), 32'h00);
        check("pad_o_3c", 32'(pad_o),  32'h3C);
        tick(1);
        check("turn_e1", 32'(pad_oe), 32'h00);
        tick(1);
        check("turn_e2", 32'(pad_oe), 32'h08);
        oe_i = 8'h00;
        tick(1);
        check("release", 32'(pad_oe), 32'h00);

        // 5) ce_i=0 freezes pad_o, pad_oe and the turn counter
        oe_i = 8'h08;
        tick(1);
        ce_i   = 1'b0;
        dout_i = 8'hA5;
        tick(5);
        check("ce0_pad_o",  32'(pad_o),  32'h3C);
        check("ce0_pad_oe", 32'(pad_oe), 32'h00);
        ce_i = 1'b1;
        tick(1);
        check("ce1_pad_o",  32'(pad_o),  32'hA5);
        check("ce1_pad_oe", 32'(pad_oe), 32'h00);
        tick(1);
        check("ce1_drive", 32'(pad_oe), 32'h08);
        oe_i = 8'h00;
        tick(1);

        // 6) set beats clear on the same edge; clear alone then wins
        pad_i = 8'h04;
        tick(5);
        check("coll_din", 32'(din_o), 32'h04);
        evt_clr_i = 8'h04;
        tick(1);
        check("coll_rise", 32'(rise_o), 32'h04);
        tick(1);
        check("clr_rise", 32'(rise_o), 32'h00);
        evt_clr_i = 8'h00;

        // reset asserted mid-TURN returns everything at once
        oe_i = 8'hFF;
        tick(2);
        rst = 1'b1;
        #1;
        check("arst_pad_oe", 32'(pad_oe), 32'h00);
        check("arst_pad_o",  32'(pad_o),  32'h00);
        check("arst_din",    32'(din_o),  32'h00);
        tick(2);
        rst = 1'b0;
        tick(2);
        check("rerun_turn", 32'(pad_oe), 32'h00);
        tick(1);
        check("rerun_drive", 32'(pad_oe), 32'hFF);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
